// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU op codes, control-bit indices
// and the multiply/divide FSM states.
package ex_stage_pkg;

    localparam int MD_CYCLES = 32;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_NOR   = 5'd5,
        OP_SLT   = 5'd6,
        OP_SLTU  = 5'd7,
        OP_SLL   = 5'd8,
        OP_SRL   = 5'd9,
        OP_SRA   = 5'd10,
        OP_LUI   = 5'd11,
        OP_MULT  = 5'd12,
        OP_MULTU = 5'd13,
        OP_DIV   = 5'd14,
        OP_DIVU  = 5'd15,
        OP_MFHI  = 5'd16,
        OP_MFLO  = 5'd17
    } alu_op_e;

    localparam int CTRL_MEM_READ   = 0;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_MEM_TYPE   = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_REG_WRITE  = 4;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(alu_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative 32-step multiply (shift-add) / divide (restoring) unit that owns HI/LO.
// Operands are reduced to magnitudes at start; signs are re-applied at commit.
module muldiv_unit
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic        is_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        commit,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mb_q, mb_d;
    logic [31:0] a_orig_q, a_orig_d;
    logic        div_q, div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        bzero_q, bzero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        sign_a, sign_b;
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic [32:0] div_diff;
    logic [63:0] prod;
    logic [31:0] quot, rem;

    always_comb begin
        sign_a   = is_signed & a[31];
        sign_b   = is_signed & b[31];
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mb_q} : 33'd0);
        div_sh   = acc_q[63:31];
        div_diff = div_sh - {1'b0, mb_q};
        prod     = neg_res_q ? (~acc_q + 64'd1) : acc_q;
        quot     = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem      = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mb_d      = mb_q;
        a_orig_d  = a_orig_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    acc_d     = {32'd0, sign_a ? (~a + 32'd1) : a};
                    mb_d      = sign_b ? (~b + 32'd1) : b;
                    a_orig_d  = a;
                    div_d     = is_div;
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    bzero_d   = (b == 32'd0);
                    cnt_d     = 5'd0;
                    state_d   = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (div_q) begin
                    // Restoring step: keep the shifted remainder when the trial subtract borrows
                    if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                    else               acc_d = {div_sh[31:0],   acc_q[30:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(MD_CYCLES - 1)) state_d = MD_DONE;
            end
            MD_DONE: begin
                if (commit) begin
                    if (!div_q) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (bzero_q) begin
                        hi_d = a_orig_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase

        if (abort && state_q != MD_IDLE) begin
            state_d = MD_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            mb_q      <= 32'd0;
            a_orig_q  <= 32'd0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mb_q      <= mb_d;
            a_orig_q  <= a_orig_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == MD_IDLE && start) || (state_q == MD_BUSY);
    assign done = (state_q == MD_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch target, and the
// iterative multiply/divide unit, all feeding a registered interface to mem_stage.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        we,
    input  logic [4:0]  op,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] imm,
    input  logic        alu_src,
    input  logic [31:0] pc_next,
    input  logic        is_branch,
    input  logic [4:0]  ctrl_in,
    input  logic [4:0]  reg_addr,
    input  logic [4:0]  fwd_reg,
    input  logic [31:0] fwd_data,
    input  logic        fwd_write,
    output logic        stall,
    output logic [31:0] alu_out,
    output logic        alu_zero,
    output logic [31:0] data_t,
    output logic [31:0] pc_branch,
    output logic        is_branch_out,
    output logic [4:0]  ctrl_out,
    output logic [4:0]  reg_addr_out
);

    alu_op_e     op_e;
    logic [31:0] op_a, fwd_t, op_b, res;
    logic        md_op, md_start, md_busy, md_done, md_commit;
    logic [31:0] hi, lo;
    logic [4:0]  ctrl_cap;

    logic [31:0] alu_out_q, alu_out_d;
    logic        alu_zero_q, alu_zero_d;
    logic [31:0] data_t_q, data_t_d;
    logic [31:0] pc_branch_q, pc_branch_d;
    logic        is_branch_q, is_branch_d;
    logic [4:0]  ctrl_q, ctrl_d;
    logic [4:0]  reg_addr_q, reg_addr_d;

    assign op_e = alu_op_e'(op);
    assign op_a = (fwd_write && fwd_reg != 5'd0 && fwd_reg == rs_addr) ? fwd_data : rs_data;
    assign fwd_t = (fwd_write && fwd_reg != 5'd0 && fwd_reg == rt_addr) ? fwd_data : rt_data;
    assign op_b = alu_src ? imm : fwd_t;

    // Start is gated by reset so stall reads 0 while the stage is held in reset
    assign md_op     = is_muldiv(op_e);
    assign md_start  = md_op && we && !flush && reset;
    assign md_commit = md_done && we && !flush;
    assign stall     = md_busy;

    muldiv_unit u_muldiv (
        .clk       (clk),
        .rst_n     (reset),
        .start     (md_start),
        .is_signed (op_e == OP_MULT || op_e == OP_DIV),
        .is_div    (op_e == OP_DIV || op_e == OP_DIVU),
        .a         (op_a),
        .b         (op_b),
        .commit    (md_commit),
        .abort     (flush),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (hi),
        .lo        (lo)
    );

    always_comb begin
        res = 32'd0;
        case (op_e)
            OP_ADD:  res = op_a + op_b;
            OP_SUB:  res = op_a - op_b;
            OP_AND:  res = op_a & op_b;
            OP_OR:   res = op_a | op_b;
            OP_XOR:  res = op_a ^ op_b;
            OP_NOR:  res = ~(op_a | op_b);
            OP_SLT:  res = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_SLTU: res = {31'd0, op_a < op_b};
            OP_SLL:  res = op_a << op_b[4:0];
            OP_SRL:  res = op_a >> op_b[4:0];
            OP_SRA:  res = 32'($signed(op_a) >>> op_b[4:0]);
            OP_LUI:  res = {op_b[15:0], 16'd0};
            OP_MFHI: res = hi;
            OP_MFLO: res = lo;
            default: res = 32'd0;
        endcase
    end

    always_comb begin
        ctrl_cap = ctrl_in;
        if (md_op) ctrl_cap[CTRL_REG_WRITE] = 1'b0;

        alu_out_d   = alu_out_q;
        alu_zero_d  = alu_zero_q;
        data_t_d    = data_t_q;
        pc_branch_d = pc_branch_q;
        is_branch_d = is_branch_q;
        ctrl_d      = ctrl_q;
        reg_addr_d  = reg_addr_q;

        if (flush || (we && stall)) begin
            alu_out_d   = 32'd0;
            alu_zero_d  = 1'b0;
            data_t_d    = 32'd0;
            pc_branch_d = 32'd0;
            is_branch_d = 1'b0;
            ctrl_d      = 5'd0;
            reg_addr_d  = 5'd0;
        end else if (we) begin
            alu_out_d   = res;
            alu_zero_d  = (res == 32'd0);
            data_t_d    = fwd_t;
            pc_branch_d = pc_next + {imm[29:0], 2'b00};
            is_branch_d = is_branch;
            ctrl_d      = ctrl_cap;
            reg_addr_d  = reg_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_out_q   <= 32'd0;
            alu_zero_q  <= 1'b0;
            data_t_q    <= 32'd0;
            pc_branch_q <= 32'd0;
            is_branch_q <= 1'b0;
            ctrl_q      <= 5'd0;
            reg_addr_q  <= 5'd0;
        end else begin
            alu_out_q   <= alu_out_d;
            alu_zero_q  <= alu_zero_d;
            data_t_q    <= data_t_d;
            pc_branch_q <= pc_branch_d;
            is_branch_q <= is_branch_d;
            ctrl_q      <= ctrl_d;
            reg_addr_q  <= reg_addr_d;
        end
    end

    assign alu_out       = alu_out_q;
    assign alu_zero      = alu_zero_q;
    assign data_t        = data_t_q;
    assign pc_branch     = pc_branch_q;
    assign is_branch_out = is_branch_q;
    assign ctrl_out      = ctrl_q;
    assign reg_addr_out  = reg_addr_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, branch target,
// multiply/divide latency and results, flush abort and mid-operation reset.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk, reset, flush, we;
    logic [4:0]  op, rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data, imm;
    logic        alu_src;
    logic [31:0] pc_next;
    logic        is_branch;
    logic [4:0]  ctrl_in, reg_addr, fwd_reg;
    logic [31:0] fwd_data;
    logic        fwd_write;
    logic        stall;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic [31:0] data_t, pc_branch;
    logic        is_branch_out;
    logic [4:0]  ctrl_out, reg_addr_out;

    int checks = 0;
    int fails  = 0;

    ex_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .we(we), .op(op),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .imm(imm), .alu_src(alu_src), .pc_next(pc_next), .is_branch(is_branch),
        .ctrl_in(ctrl_in), .reg_addr(reg_addr), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .fwd_write(fwd_write), .stall(stall), .alu_out(alu_out), .alu_zero(alu_zero),
        .data_t(data_t), .pc_branch(pc_branch), .is_branch_out(is_branch_out),
        .ctrl_out(ctrl_out), .reg_addr_out(reg_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_addr = 5'd1; rt_addr = 5'd2; rs_data = a; rt_data = b;
        alu_src = 1'b0; imm = 32'd0; fwd_write = 1'b0; fwd_reg = 5'd0; is_branch = 1'b0;
    endtask

    // Runs a mul/div op until stall drops, then commits it; returns stall cycle count.
    task automatic run_md(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        drive(o, a, b);
        we = 1'b1;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if (alu_out !== 32'd0 || ctrl_out !== 5'd0 || pc_branch !== 32'd0 || data_t !== 32'd0 ||
            alu_zero !== 1'b0 || is_branch_out !== 1'b0 || reg_addr_out !== 5'd0) begin
            $display("FAIL reset_outputs alu_out=%h ctrl=%b pcb=%h exp all zero", alu_out, ctrl_out, pc_branch);
            fails++;
        end
        checks++;
        if (stall !== 1'b0) begin
            $display("FAIL reset_stall got=%b exp=0", stall); fails++;
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_forward();
        op = OP_ADD; rs_addr = 5'd5; rs_data = 32'd7; rt_addr = 5'd6; rt_data = 32'd9;
        alu_src = 1'b0; fwd_write = 1'b1; fwd_reg = 5'd5; fwd_data = 32'd100;
        ctrl_in = 5'b10000; reg_addr = 5'd3; we = 1'b1;
        tick();
        checks++;
        if (alu_out !== 32'd109 || alu_zero !== 1'b0) begin
            $display("FAIL fwd_rs alu_out=%0d zero=%b exp 109/0", alu_out, alu_zero); fails++;
        end
        checks++;
        if (ctrl_out !== 5'b10000 || reg_addr_out !== 5'd3 || data_t !== 32'd9) begin
            $display("FAIL fwd_ctrl ctrl=%b ra=%0d dt=%0d exp 10000/3/9", ctrl_out, reg_addr_out, data_t); fails++;
        end
        fwd_reg = 5'd0;
        tick();
        checks++;
        if (alu_out !== 32'd16) begin
            $display("FAIL fwd_r0 alu_out=%0d exp 16", alu_out); fails++;
        end
        fwd_reg = 5'd6;
        tick();
        checks++;
        if (alu_out !== 32'd107 || data_t !== 32'd100) begin
            $display("FAIL fwd_rt alu_out=%0d dt=%0d exp 107/100", alu_out, data_t); fails++;
        end
        fwd_write = 1'b0; fwd_reg = 5'd5;
        tick();
        checks++;
        if (alu_out !== 32'd16) begin
            $display("FAIL fwd_nowrite alu_out=%0d exp 16", alu_out); fails++;
        end
        we = 1'b0; rs_data = 32'd1;
        tick();
        checks++;
        if (alu_out !== 32'd16) begin
            $display("FAIL hold_we0 alu_out=%0d exp 16", alu_out); fails++;
        end
        we = 1'b1;
    endtask

    task automatic test_branch();
        drive(OP_SUB, 32'd3, 32'd3);
        is_branch = 1'b1; pc_next = 32'h100; imm = 32'd4; ctrl_in = 5'b00000;
        tick();
        checks++;
        if (alu_zero !== 1'b1 || pc_branch !== 32'h110 || is_branch_out !== 1'b1 || alu_out !== 32'd0) begin
            $display("FAIL branch zero=%b pcb=%h br=%b exp 1/110/1", alu_zero, pc_branch, is_branch_out); fails++;
        end
        is_branch = 1'b0;
    endtask

    task automatic test_alu_ops();
        logic [4:0]  t_op  [11] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
                                    OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_SUB};
        logic [31:0] t_a   [11] = '{32'hF0F0, 32'hF0F0, 32'hFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                    32'h1, 32'h80000000, 32'h80000000, 32'h0, 32'd5};
        logic [31:0] t_b   [11] = '{32'hFF00, 32'h0F0F, 32'h0F, 32'h0, 32'h1, 32'h1,
                                    32'd4, 32'd4, 32'd4, 32'h1234, 32'd7};
        logic [31:0] t_exp [11] = '{32'hF000, 32'hFFFF, 32'hF0, 32'hFFFFFFFF, 32'h1, 32'h0,
                                    32'h10, 32'h08000000, 32'hF8000000, 32'h12340000, 32'hFFFFFFFE};
        for (int i = 0; i < 11; i++) begin
            drive(t_op[i], t_a[i], 32'd0);
            alu_src = 1'b1; imm = t_b[i];
            tick();
            checks++;
            if (alu_out !== t_exp[i]) begin
                $display("FAIL alu_op%0d got=%h exp=%h", t_op[i], alu_out, t_exp[i]); fails++;
            end
        end
    endtask

    task automatic test_mult();
        int n;
        logic bad;
        drive(OP_MULT, 32'hFFFFFFFD, 32'd5);
        ctrl_in = 5'b10000; reg_addr = 5'd4; we = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            $display("FAIL mult_stall_start got=%b exp=1", stall); fails++;
        end
        n = 0; bad = 1'b0;
        while (stall === 1'b1 && n < 100) begin
            tick();
            n++;
            if (alu_out !== 32'd0 || ctrl_out !== 5'd0 || reg_addr_out !== 5'd0) bad = 1'b1;
        end
        checks++;
        if (n != 33) begin
            $display("FAIL mult_stall_cycles got=%0d exp=33", n); fails++;
        end
        checks++;
        if (bad !== 1'b0) begin
            $display("FAIL mult_bubbles non-bubble output seen while stalled"); fails++;
        end
        tick();
        checks++;
        if (ctrl_out !== 5'b00000 || reg_addr_out !== 5'd4) begin
            $display("FAIL mult_leave ctrl=%b ra=%0d exp 00000/4", ctrl_out, reg_addr_out); fails++;
        end
        drive(OP_MFLO, 32'd0, 32'd0);
        tick();
        checks++;
        if (alu_out !== 32'hFFFFFFF1) begin
            $display("FAIL mult_lo got=%h exp=fffffff1", alu_out); fails++;
        end
        drive(OP_MFHI, 32'd0, 32'd0);
        tick();
        checks++;
        if (alu_out !== 32'hFFFFFFFF) begin
            $display("FAIL mult_hi got=%h exp=ffffffff", alu_out); fails++;
        end
    endtask

    task automatic test_div();
        int n;
        run_md(OP_DIV, 32'hFFFFFFF9, 32'd2, n);
        drive(OP_MFLO, 32'd0, 32'd0);
        tick();
        checks++;
        if (alu_out !== 32'hFFFFFFFD) begin
            $display("FAIL div_lo got=%h exp=fffffffd", alu_out); fails++;
        end
        drive(OP_MFHI, 32'd0, 32'd0);
        tick();
        checks++;
        if (alu_out !== 32'hFFFFFFFF) begin
            $display("FAIL div_hi got=%h exp=ffffffff", alu_out); fails++;
        end
        run_md(OP_DIVU, 32'd10, 32'd0, n);
        checks++;
        if (n != 33) begin
            $display("FAIL divz_cycles got=%0d exp=33", n); fails++;
        end
        drive(OP_MFLO, 32'd0, 32'd0);
        tick();
        checks++;
        if (alu_out !== 32'hFFFFFFFF) begin
            $display("FAIL divz_lo got=%h exp=ffffffff", alu_out); fails++;
        end
        drive(OP_MFHI, 32'd0, 32'd0);
        tick();
        checks++;
        if (alu_out !== 32'd10) begin
            $display("FAIL divz_hi got=%h exp=0000000a", alu_out); fails++;
        end
    endtask

    task automatic test_flush();
        drive(OP_DIVU, 32'd100, 32'd7);
        ctrl_in = 5'b10000; we = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; we = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            $display("FAIL flush_stall got=%b exp=0", stall); fails++;
        end
        checks++;
        if (alu_out !== 32'd0 || ctrl_out !== 5'd0) begin
            $display("FAIL flush_bubble alu_out=%h ctrl=%b exp 0/0", alu_out, ctrl_out); fails++;
        end
        we = 1'b1;
        drive(OP_MFHI, 32'd0, 32'd0);
        tick();
        checks++;
        if (alu_out !== 32'd10) begin
            $display("FAIL flush_hi got=%h exp=0000000a", alu_out); fails++;
        end
        drive(OP_MFLO, 32'd0, 32'd0);
        tick();
        checks++;
        if (alu_out !== 32'hFFFFFFFF) begin
            $display("FAIL flush_lo got=%h exp=ffffffff", alu_out); fails++;
        end
    endtask

    task automatic test_reset_mid();
        drive(OP_MULTU, 32'd3, 32'd4);
        ctrl_in = 5'b10000; we = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || alu_out !== 32'd0 || ctrl_out !== 5'd0 || pc_branch !== 32'd0) begin
            $display("FAIL rst_mid stall=%b alu_out=%h ctrl=%b exp all zero", stall, alu_out, ctrl_out); fails++;
        end
        tick();
        drive(OP_MFHI, 32'd0, 32'd0);
        reset = 1'b1;
        tick();
        checks++;
        if (alu_out !== 32'd0) begin
            $display("FAIL rst_mid_hi got=%h exp=0", alu_out); fails++;
        end
        drive(OP_MFLO, 32'd0, 32'd0);
        tick();
        checks++;
        if (alu_out !== 32'd0) begin
            $display("FAIL rst_mid_lo got=%h exp=0", alu_out); fails++;
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; we = 1'b1;
        drive(OP_ADD, 32'd0, 32'd0);
        pc_next = 32'd0; ctrl_in = 5'd0; reg_addr = 5'd0; fwd_data = 32'd0;
        #12;
        test_reset();
        test_forward();
        test_branch();
        test_alu_ops();
        test_mult();
        test_div();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage pipeline. It sits between the decode stage and mem_stage.
- Resolves rs/rt forwarding from mem_stage's probe outputs.
- Performs single-cycle ALU ops, branch-target and zero computation, and iterative 32-cycle multiply/divide into HI/LO.
- Registers the result, store data and control bits that feed mem_stage directly.

Parameters:
MD_CYCLES, 32, iterations of the multiply/divide unit; fixed at 32 for 32-bit operands.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
flush  in  1  synchronous; squashes the output register and aborts multiply/divide
we  in  1  stage advance enable; 0 holds the output register
op  in  5  ALU operation code, defined in alu_defs.vh
rs_addr  in  5  source register A index
rt_addr  in  5  source register B index
rs_data  in  32  register-file value for rs
rt_data  in  32  register-file value for rt
imm  in  32  sign- or zero-extended immediate; shamt in imm[4:0] for shifts
alu_src  in  1  1: operand B = imm; 0: operand B = forwarded rt
pc_next  in  32  PC+4 of this instruction
is_branch  in  1  instruction is a conditional branch
ctrl_in  in  5  {reg_write, mem_to_reg, mem_type, mem_write, mem_read}
reg_addr  in  5  destination register
fwd_reg  in  5  mem_stage reg_probe
fwd_data  in  32  mem_stage data_probe
fwd_write  in  1  mem_stage write_probe
stall  out  1  combinational; 1 = upstream must hold its instruction
alu_out  out  32  registered result
alu_zero  out  1  registered (result == 0)
data_t  out  32  registered forwarded rt (store data)
pc_branch  out  32  registered pc_next + (imm << 2)
is_branch_out  out  1  registered is_branch
ctrl_out  out  5  registered ctrl_in
reg_addr_out  out  5  registered reg_addr

Behaviour:
Reset:
- All outputs 0; HI = LO = 0; multiply/divide FSM in IDLE.

Forwarding:
- Operand A = fwd_data if fwd_write && fwd_reg != 0 && fwd_reg == rs_addr; otherwise rs_data.
- Forwarded rt uses the same rule against rt_addr.
- Operand B = alu_src ? imm : forwarded rt.

Single-cycle ops (all arithmetic modulo 2^32, no overflow trap):
- ADD, SUB, AND, OR, XOR, NOR.
- SLT (signed) and SLTU; result is 0 or 1.
- SLL, SRL, SRA: shift A by B[4:0].
- LUI: B << 16.
- MFHI, MFLO: return HI or LO.

Output register:
- On a rising edge with we=1 and stall=0, captures all outputs.
- flush has priority over we: loads a bubble (ctrl_out=0, is_branch_out=0, all data outputs 0).
- While stall=1 and we=1, loads a bubble each cycle.

Multiply/divide FSM (IDLE, BUSY, DONE):
- IDLE:
  - op in {MULT, MULTU, DIV, DIVU} with we=1: latch operand magnitudes and signs (signed ops only), counter = 0, go BUSY. stall = 1 in this same cycle.
  - Otherwise stall = 0.
- BUSY:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle; stall = 1.
  - When counter == 31, go DONE.
- DONE:
  - stall = 0.
  - When we=1: commit HI/LO and go IDLE. Multiply: {HI,LO} = 64-bit product. Divide: LO = quotient, HI = remainder.
  - The instruction leaves this stage with ctrl_out reg_write = 0.
  - When we=0: hold DONE.
- Signed fix-up: negate the product/quotient if sign_a ^ sign_b; remainder takes sign_a. Magnitude of -2^31 is 32'h80000000 (unsigned).
- Divide by zero (B == 0): HI = original A, LO = 32'hFFFFFFFF for both DIV and DIVU; still takes 32 cycles.
- Cycle counts: stall is high for 33 cycles; the instruction occupies the stage for 34 cycles when we stays 1.
- flush in BUSY or DONE: return to IDLE, HI/LO unchanged, stall = 0 on the next cycle.
- Reset mid-operation: immediate return to IDLE; HI = LO = 0.
- MFHI/MFLO issued directly after a DONE commit read the new HI/LO.

Decomposition:
- alu_defs.vh: op encodings (ADD=0 … MFLO=17) and ctrl bit indices (CTRL_MEM_READ=0 … CTRL_REG_WRITE=4). Included by ex_stage and the decoder.
- One sub-module, muldiv_unit: owns the FSM, counter, accumulator, HI/LO, sign fix-up and divide-by-zero override. Interface: start, signed, is_div, a, b, commit, abort, busy, hi, lo.

Test Plan:
- ADD rs=5 (rs_data=7), rt=6 (rt_data=9), fwd_write=1, fwd_reg=5, fwd_data=100 -> alu_out=109, alu_zero=0; with fwd_reg=0 -> alu_out=16.
- SUB A=3, B=3, is_branch=1, pc_next=0x100, imm=4 -> alu_zero=1, pc_branch=0x110, is_branch_out=1.
- MULT A=-3, B=5 -> stall high exactly 33 cycles, bubbles at output meanwhile; then MFLO -> 0xFFFFFFF1 and MFHI -> 0xFFFFFFFF.
- DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=10, B=0 -> LO=0xFFFFFFFF, HI=10.
- DIVU started, flush asserted at BUSY cycle 10 -> stall=0 next cycle, HI/LO keep prior values, output register holds a bubble.
- reset low mid-MULTU -> all outputs 0, stall=0; after release, MFHI -> 0.
